// File: rtl/pc_seq_unit_pkg.sv
// Control encodings shared by the PC sequencer: next-PC opcodes and vectors.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pc_seq_unit_pkg;

  // PLUS4/BRANCH/JUMP/JR keep their legacy 2-bit codes, zero-extended.
  typedef enum logic [2:0] {
    OP_PLUS4  = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JUMP   = 3'd2,
    OP_JR     = 3'd3,
    OP_JAL    = 3'd4,
    OP_RET    = 3'd5
  } npc_op_e;

  // Kept 64 bits wide so any legal PC width can slice them.
  localparam logic [63:0] RESET_VEC_DEF = 64'h0000_0000_0000_3000;
  localparam logic [63:0] EXC_VEC_DEF   = 64'h0000_0000_0000_4180;

endpackage

// File: rtl/pc_seq_unit_ras_stack.sv
// Return-address stack as a circular buffer; a push into a full stack drops the oldest entry.
// Latency: push/pop take effect at the next edge; top is combinational from state.
// Backpressure: none; pop on empty is ignored, push on full overwrites.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;   // slot the next push writes; top sits just below it
  logic [CW-1:0] count;

  // Newest entry is the one most recently written.
  assign top = mem[wptr - PW'(1)];

  // Pointer, occupancy and flag updates; wptr wraps so a full push lands on the oldest slot.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr  <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else if (push) begin
      mem[wptr] <= push_data;
      wptr      <= wptr + PW'(1);
      if (count != CW'(DEPTH)) begin
        count <= count + CW'(1);
      end
      empty <= 1'b0;
      full  <= (count >= CW'(DEPTH - 1));
    end else if (pop && (count != '0)) begin
      wptr  <= wptr - PW'(1);
      count <= count - CW'(1);
      empty <= (count == CW'(1));
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: next-PC selection, exception entry/return and return-address prediction.
// Latency: npc is combinational; pc/epc/flags/mispredict update one edge later.
// Backpressure: stall holds all state; exc_req and reset override it.
module pc_seq_unit
  import pc_seq_unit_pkg::*;
#(
  parameter int            AW        = 32,
  parameter logic [AW-1:0] RESET_VEC = RESET_VEC_DEF[AW-1:0],
  parameter logic [AW-1:0] EXC_VEC   = EXC_VEC_DEF[AW-1:0],
  parameter int            RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          stall,
  input  logic [2:0]    npc_op,
  input  logic [25:0]   imm,
  input  logic [AW-1:0] pcjr,
  input  logic          exc_req,
  input  logic          eret,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] npc,
  output logic [AW-1:0] epc,
  output logic          ras_empty,
  output logic          ras_full,
  output logic          ras_mispredict
);

  logic [AW-1:0] pc4;
  logic [AW-1:0] br_tgt;
  logic [AW-1:0] jmp_tgt;
  logic [AW-1:0] op_npc;
  logic [AW-1:0] ras_top;
  logic          accept;
  logic          do_push;
  logic          do_pop;
  logic          ret_miss;

  assign pc4     = pc + AW'(4);
  assign br_tgt  = pc4 + {{(AW-18){imm[15]}}, imm[15:0], 2'b00};
  assign jmp_tgt = {pc4[AW-1:28], imm, 2'b00};

  // An edge "accepts" the opcode only when nothing of higher priority claims it.
  assign accept   = rstn & ~exc_req & ~stall & ~eret;
  assign do_push  = accept && (npc_op == OP_JAL);
  assign do_pop   = accept && (npc_op == OP_RET);
  assign ret_miss = ras_empty || (ras_top != pcjr);

  // Next-PC: opcode result, then overridden by eret, stall, exception and reset in rising priority.
  always_comb begin
    case (npc_op)
      OP_BRANCH:      op_npc = br_tgt;
      OP_JUMP, OP_JAL: op_npc = jmp_tgt;
      OP_JR, OP_RET:  op_npc = pcjr;
      default:        op_npc = pc4;
    endcase

    npc = op_npc;
    if (!rstn) begin
      npc = RESET_VEC;
    end else if (exc_req) begin
      npc = EXC_VEC;
    end else if (stall) begin
      npc = pc;
    end else if (eret) begin
      npc = epc;
    end
  end

  // PC, EPC and mispredict pulse; stall freezes everything including the pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc             <= RESET_VEC;
      epc            <= '0;
      ras_mispredict <= 1'b0;
    end else if (exc_req) begin
      pc             <= EXC_VEC;
      epc            <= pc;
      ras_mispredict <= 1'b0;
    end else if (!stall) begin
      pc             <= npc;
      ras_mispredict <= do_pop & ret_miss;
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (AW)
  ) u_ras (
    .clk       (clk),
    .rstn      (rstn),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (pc4),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: directed scenarios plus randomized traffic against a queue-based model.
// Latency: checks npc before each edge and registered outputs 1 time unit after it.
// Backpressure: exercised through stall, exc_req and eret.
module tb_pc_seq_unit;
  import pc_seq_unit_pkg::*;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic [2:0]  npc_op;
  logic [25:0] imm;
  logic [31:0] pcjr;
  logic        exc_req;
  logic        eret;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] epc;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_mispredict;

  int errors = 0;
  int checks = 0;

  // Reference state: architectural PC/EPC and a bounded list of return addresses.
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_mis;
  logic [31:0] m_ras[$];

  pc_seq_unit dut (
    .clk            (clk),
    .rstn           (rstn),
    .stall          (stall),
    .npc_op         (npc_op),
    .imm            (imm),
    .pcjr           (pcjr),
    .exc_req        (exc_req),
    .eret           (eret),
    .pc             (pc),
    .npc            (npc),
    .epc            (epc),
    .ras_empty      (ras_empty),
    .ras_full       (ras_full),
    .ras_mispredict (ras_mispredict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] model_npc();
    logic [31:0] pc4;
    int          off;
    pc4 = m_pc + 32'd4;
    if (!rstn)   return 32'h3000;
    if (exc_req) return 32'h4180;
    if (stall)   return m_pc;
    if (eret)    return m_epc;
    case (npc_op)
      OP_BRANCH: begin
        off = $signed(imm[15:0]);
        return pc4 + 32'(off * 4);
      end
      OP_JUMP, OP_JAL: return (pc4 & 32'hF000_0000) | ({6'b0, imm} << 2);
      OP_JR, OP_RET:   return pcjr;
      default:         return pc4;
    endcase
  endfunction

  function automatic void model_step();
    logic [31:0] n;
    n = model_npc();
    if (!rstn) begin
      m_pc = 32'h3000; m_epc = 32'h0; m_mis = 1'b0; m_ras.delete();
    end else if (exc_req) begin
      m_epc = m_pc; m_pc = n; m_mis = 1'b0;
    end else if (!stall) begin
      m_mis = 1'b0;
      if (!eret && npc_op == OP_JAL) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end else if (!eret && npc_op == OP_RET) begin
        m_mis = (m_ras.size() == 0) || (m_ras[$] != pcjr);
        if (m_ras.size() > 0) void'(m_ras.pop_back());
      end
      m_pc = n;
    end
  endfunction

  task automatic idle();
    rstn = 1'b1; stall = 1'b0; exc_req = 1'b0; eret = 1'b0;
    npc_op = OP_PLUS4; imm = '0; pcjr = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    idle(); rstn = 1'b0; cycle(); idle();
  endtask

  task automatic test_reset();
    idle();
    rstn = 1'b0; stall = 1'b1; exc_req = 1'b1; eret = 1'b1;
    cycle(); cycle();
    checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h3000); end
    checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h want %h", epc, 32'h0); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", ras_empty); end
    checks++; if (ras_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", ras_full); end
    checks++; if (ras_mispredict !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b want 0", ras_mispredict); end
    idle();
  endtask

  task automatic test_plus4();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h3004; exp_pc[1] = 32'h3008; exp_pc[2] = 32'h300C;
    for (int i = 0; i < 3; i++) begin
      npc_op = OP_PLUS4; #1;
      checks++; if (npc !== exp_pc[i]) begin errors++; $display("FAIL plus4_npc%0d: got %h want %h", i, npc, exp_pc[i]); end
      cycle();
      checks++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL plus4_pc%0d: got %h want %h", i, pc, exp_pc[i]); end
    end
  endtask

  task automatic test_branch();
    cycle();  // 0x300C -> 0x3010
    checks++; if (pc !== 32'h3010) begin errors++; $display("FAIL branch_setup_pc: got %h want %h", pc, 32'h3010); end
    npc_op = OP_BRANCH; imm = 26'h000FFFF; #1;
    checks++; if (npc !== 32'h3010) begin errors++; $display("FAIL branch_neg_npc: got %h want %h", npc, 32'h3010); end
    imm = 26'h0000003; #1;
    checks++; if (npc !== 32'h3020) begin errors++; $display("FAIL branch_pos_npc: got %h want %h", npc, 32'h3020); end
    cycle();
    checks++; if (pc !== 32'h3020) begin errors++; $display("FAIL branch_pc: got %h want %h", pc, 32'h3020); end
    idle();
  endtask

  task automatic test_jal_ret();
    do_reset();
    npc_op = OP_JAL; imm = 26'h0000C00; #1;
    checks++; if (npc !== 32'h3000) begin errors++; $display("FAIL jal_npc: got %h want %h", npc, 32'h3000); end
    cycle();
    checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL jal_pc: got %h want %h", pc, 32'h3000); end
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL jal_empty: got %b want 0", ras_empty); end
    npc_op = OP_RET; pcjr = 32'h3004; cycle();
    checks++; if (ras_mispredict !== 1'b0) begin errors++; $display("FAIL ret_hit_mis: got %b want 0", ras_mispredict); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ret_hit_empty: got %b want 1", ras_empty); end
    checks++; if (pc !== 32'h3004) begin errors++; $display("FAIL ret_pc: got %h want %h", pc, 32'h3004); end
    cycle();
    checks++; if (ras_mispredict !== 1'b1) begin errors++; $display("FAIL ret_empty_mis: got %b want 1", ras_mispredict); end
    idle(); cycle();
    checks++; if (ras_mispredict !== 1'b0) begin errors++; $display("FAIL mis_pulse_clear: got %b want 0", ras_mispredict); end
  endtask

  task automatic test_exception();
    do_reset(); cycle(); cycle();  // pc = 0x3008
    exc_req = 1'b1; stall = 1'b1; #1;
    checks++; if (npc !== 32'h4180) begin errors++; $display("FAIL exc_npc: got %h want %h", npc, 32'h4180); end
    cycle();
    checks++; if (pc !== 32'h4180) begin errors++; $display("FAIL exc_pc: got %h want %h", pc, 32'h4180); end
    checks++; if (epc !== 32'h3008) begin errors++; $display("FAIL exc_epc: got %h want %h", epc, 32'h3008); end
    idle(); eret = 1'b1; #1;
    checks++; if (npc !== 32'h3008) begin errors++; $display("FAIL eret_npc: got %h want %h", npc, 32'h3008); end
    cycle();
    checks++; if (pc !== 32'h3008) begin errors++; $display("FAIL eret_pc: got %h want %h", pc, 32'h3008); end
    idle(); cycle();  // pc = 0x300C
    exc_req = 1'b1; eret = 1'b1; cycle();
    checks++; if (pc !== 32'h4180) begin errors++; $display("FAIL exc_eret_pc: got %h want %h", pc, 32'h4180); end
    checks++; if (epc !== 32'h300C) begin errors++; $display("FAIL exc_eret_epc: got %h want %h", epc, 32'h300C); end
    idle();
  endtask

  task automatic test_overflow();
    logic [31:0] ra [5];
    do_reset();
    for (int k = 0; k < 5; k++) begin
      ra[k] = m_pc + 32'd4;
      npc_op = OP_JAL; imm = 26'h0000C00 + 26'(k * 4);
      cycle();
    end
    checks++; if (ras_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", ras_full); end
    checks++; if (pc !== 32'h3040) begin errors++; $display("FAIL ovf_pc: got %h want %h", pc, 32'h3040); end
    for (int k = 4; k >= 1; k--) begin
      npc_op = OP_RET; pcjr = ra[k]; cycle();
      checks++; if (ras_mispredict !== 1'b0) begin errors++; $display("FAIL ovf_ret%0d_mis: got %b want 0", k, ras_mispredict); end
      checks++; if (pc !== ra[k]) begin errors++; $display("FAIL ovf_ret%0d_pc: got %h want %h", k, pc, ra[k]); end
    end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b want 1", ras_empty); end
    pcjr = ra[0]; cycle();
    checks++; if (ras_mispredict !== 1'b1) begin errors++; $display("FAIL ovf_ret5_mis: got %b want 1", ras_mispredict); end
    idle();
  endtask

  task automatic test_stall_reset();
    do_reset();
    exc_req = 1'b1; cycle(); idle();          // epc = 0x3000
    eret = 1'b1; cycle(); idle();             // pc = 0x3000
    npc_op = OP_JAL; imm = 26'h0000C00; cycle(); cycle();
    npc_op = OP_RET; pcjr = 32'h1234; cycle();
    checks++; if (ras_mispredict !== 1'b1) begin errors++; $display("FAIL pre_stall_mis: got %b want 1", ras_mispredict); end
    for (int i = 0; i < 3; i++) begin
      idle(); stall = 1'b1; eret = 1'b1; npc_op = 3'($urandom_range(0, 7)); imm = 26'($urandom);
      cycle();
      checks++; if (pc !== 32'h1234) begin errors++; $display("FAIL stall%0d_pc: got %h want %h", i, pc, 32'h1234); end
      checks++; if (epc !== 32'h3000) begin errors++; $display("FAIL stall%0d_epc: got %h want %h", i, epc, 32'h3000); end
      checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL stall%0d_empty: got %b want 0", i, ras_empty); end
      checks++; if (ras_mispredict !== 1'b1) begin errors++; $display("FAIL stall%0d_mis: got %b want 1", i, ras_mispredict); end
    end
    rstn = 1'b0; cycle();
    checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL stall_rst_pc: got %h want %h", pc, 32'h3000); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL stall_rst_empty: got %b want 1", ras_empty); end
    checks++; if (ras_mispredict !== 1'b0) begin errors++; $display("FAIL stall_rst_mis: got %b want 0", ras_mispredict); end
    idle(); npc_op = OP_RET; pcjr = 32'h3004; cycle();
    checks++; if (ras_mispredict !== 1'b1) begin errors++; $display("FAIL rst_discard_mis: got %b want 1", ras_mispredict); end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] exp_npc;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rstn    = ($urandom_range(0, 39) != 0);
      stall   = ($urandom_range(0, 7) == 0);
      exc_req = ($urandom_range(0, 19) == 0);
      eret    = ($urandom_range(0, 11) == 0);
      npc_op  = 3'($urandom_range(0, 7));
      imm     = 26'($urandom);
      if (m_ras.size() > 0 && $urandom_range(0, 2) != 0) pcjr = m_ras[$];
      else pcjr = 32'($urandom) & 32'hFFFF_FFFC;
      #1;
      exp_npc = model_npc();
      checks++; if (npc !== exp_npc) begin errors++; $display("FAIL rnd%0d_npc: got %h want %h", i, npc, exp_npc); end
      cycle();
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd%0d_pc: got %h want %h", i, pc, m_pc); end
      checks++; if (epc !== m_epc) begin errors++; $display("FAIL rnd%0d_epc: got %h want %h", i, epc, m_epc); end
      checks++; if (ras_empty !== (m_ras.size() == 0)) begin errors++; $display("FAIL rnd%0d_empty: got %b want %b", i, ras_empty, m_ras.size() == 0); end
      checks++; if (ras_full !== (m_ras.size() == 4)) begin errors++; $display("FAIL rnd%0d_full: got %b want %b", i, ras_full, m_ras.size() == 4); end
      checks++; if (ras_mispredict !== m_mis) begin errors++; $display("FAIL rnd%0d_mis: got %b want %b", i, ras_mispredict, m_mis); end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_plus4();
    test_branch();
    test_jal_ret();
    test_exception();
    test_overflow();
    test_stall_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
